// File: rtl/uart_dbg_pkg.sv
// ----------------------------------------------------------------------------
// uart_dbg_pkg
//   Shared types and defaults for the UART debugger serial link (RX and TX).
//   rx_state_t            : receive sequencer states, 3-bit encoding
//   UART_CLKS_PER_BIT_DEF : default clk cycles per serial bit
//   UART_DATA_BITS_DEF    : default data bits per frame
// ----------------------------------------------------------------------------
package uart_dbg_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      LOAD   = 3'd5
   } rx_state_t;

   localparam int UART_CLKS_PER_BIT_DEF = 10;
   localparam int UART_DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// ----------------------------------------------------------------------------
// uart_bit_timer
//   Reloadable down-counter used to time serial bit periods. A load takes
//   priority; otherwise the count decrements and holds at zero.
//   Ports:
//     clk        in  system clock, rising edge
//     n_Rst      in  asynchronous active-low reset (count cleared)
//     i_load     in  reload the counter with i_load_val this cycle
//     i_load_val in  reload value
//     o_done     out count is zero (sample point)
// ----------------------------------------------------------------------------
module uart_bit_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         n_Rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge n_Rst) begin
      if (!n_Rst)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - W'(1);
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side sequencer for the UART debugger link. Wakes on the start-bit
//   detector pulse, samples the line at mid-bit, shifts data in LSB first,
//   checks the stop bit and presents the byte via a ready/read flag pair.
//   Optional feature macro: UART_RX_PARITY_EN (adds a parity bit and check).
//   Ports:
//     clk            in  system clock, rising edge
//     n_Rst          in  asynchronous active-low reset
//     start_detected in  one-cycle pulse from the start-bit detector
//     serial_in      in  synchronized serial line, idle high
//     data_read      in  consumer acknowledges rx_data this cycle
//     rx_data        out last good frame
//     data_ready     out rx_data valid and not yet read
//     framing_error  out stop bit sampled low on the last frame
//     overrun_error  out unread frame was overwritten
//     parity_error   out parity mismatch on the last frame (0 without macro)
//     rx_busy        out sequencer not idle
// ----------------------------------------------------------------------------
module uart_rx_ctrl
   import uart_dbg_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = UART_DATA_BITS_DEF,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 n_Rst,
   input  logic                 start_detected,
   input  logic                 serial_in,
   input  logic                 data_read,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 data_ready,
   output logic                 framing_error,
   output logic                 overrun_error,
   output logic                 parity_error,
   output logic                 rx_busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int TW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TMR_BIT  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMR_HALF = TW'(HALF - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   rx_state_t r_state, w_state_nxt;

   logic                 w_tmr_load, w_tmr_done;
   logic [TW-1:0]        w_tmr_val;
   logic                 w_start, w_shift_en, w_stop_bad, w_load;
   logic [DATA_BITS-1:0] r_shift, r_rx_data;
   logic [BW-1:0]        r_bit_cnt;
   logic                 r_data_ready, r_fe, r_ovr;

   uart_bit_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .n_Rst      (n_Rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_done     (w_tmr_done)
   );

`ifdef UART_RX_PARITY_EN
   logic w_par_chk;
   logic r_pe;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge n_Rst) begin
      if (!n_Rst) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Timer is reloaded on every transition and every sample so each sample
   // lands exactly one bit period after the previous one.
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_load  = 1'b0;
      w_tmr_val   = TMR_BIT;
      w_start     = 1'b0;
      w_shift_en  = 1'b0;
      w_stop_bad  = 1'b0;
      w_load      = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_chk   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (start_detected) begin
               w_state_nxt = START;
               w_tmr_load  = 1'b1;
               w_tmr_val   = TMR_HALF;
               w_start     = 1'b1;
            end
         end
         START: begin
            if (w_tmr_done) begin
               w_tmr_load  = 1'b1;
               w_state_nxt = serial_in ? IDLE : DATA;   // high = false start
            end
         end
         DATA: begin
            if (w_tmr_done) begin
               w_tmr_load = 1'b1;
               w_shift_en = 1'b1;
               if (r_bit_cnt == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (w_tmr_done) begin
               w_tmr_load  = 1'b1;
               w_par_chk   = 1'b1;
               w_state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (w_tmr_done) begin
               w_tmr_load = 1'b1;
               if (!serial_in) begin
                  w_stop_bad  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = LOAD;
               end
            end
         end
         LOAD: begin
            w_load      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- shift register / bit counter ----------------
   always_ff @(posedge clk or negedge n_Rst) begin
      if (!n_Rst) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else begin
         if (w_start)
            r_bit_cnt <= '0;
         else if (w_shift_en)
            r_bit_cnt <= r_bit_cnt + BW'(1);
         // new bit enters at the MSB so the first (LSB) bit ends in bit 0
         if (w_shift_en)
            r_shift <= (r_shift >> 1) | (DATA_BITS'(serial_in) << (DATA_BITS - 1));
      end
   end

   // ---------------- output register and flags ----------------
   always_ff @(posedge clk or negedge n_Rst) begin
      if (!n_Rst) begin
         r_rx_data    <= '0;
         r_data_ready <= 1'b0;
         r_fe         <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         if (w_start)    r_fe <= 1'b0;
         if (w_stop_bad) r_fe <= 1'b1;
         // a load in the same cycle as a read wins: data stays ready
         if (w_load) begin
            r_rx_data    <= r_shift;
            r_data_ready <= 1'b1;
            if (r_data_ready && !data_read)
               r_ovr <= 1'b1;
            else if (r_data_ready)
               r_ovr <= 1'b0;
         end else if (data_read && r_data_ready) begin
            r_data_ready <= 1'b0;
            r_ovr        <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic w_par_exp;
   assign w_par_exp = (^r_shift) ^ PARITY_ODD[0];

   always_ff @(posedge clk or negedge n_Rst) begin
      if (!n_Rst)
         r_pe <= 1'b0;
      else if (w_start)
         r_pe <= 1'b0;
      else if (w_par_chk)
         r_pe <= serial_in ^ w_par_exp;
   end
   assign parity_error = r_pe;
`else
   logic w_unused_par_odd;
   assign w_unused_par_odd = PARITY_ODD[0];
   assign parity_error     = 1'b0;
`endif

   assign rx_data       = r_rx_data;
   assign data_ready    = r_data_ready;
   assign framing_error = r_fe;
   assign overrun_error = r_ovr;
   assign rx_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Directed plus randomized frames against a frame-level reference model.
//   Honours UART_RX_PARITY_EN (frames then carry a parity bit).
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   localparam int CPB  = 10;
   localparam int DB   = 8;
   localparam int HALF = CPB / 2;
   localparam int ODD  = 0;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NB = DB + 2 + PB;   // start + data + parity + stop

   logic          clk = 1'b0;
   logic          n_Rst, start_detected, serial_in, data_read;
   logic [DB-1:0] rx_data;
   logic          data_ready, framing_error, overrun_error, parity_error, rx_busy;

   uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(ODD)) dut (
      .clk            (clk),
      .n_Rst          (n_Rst),
      .start_detected (start_detected),
      .serial_in      (serial_in),
      .data_read      (data_read),
      .rx_data        (rx_data),
      .data_ready     (data_ready),
      .framing_error  (framing_error),
      .overrun_error  (overrun_error),
      .parity_error   (parity_error),
      .rx_busy        (rx_busy)
   );

   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_pass = 0;
   logic wave     [0:255];
   logic obs_busy [0:255];
   int   rise;

   // reference model of the visible state
   logic [DB-1:0] m_data;
   logic m_rdy, m_fe, m_ovr, m_pe;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".rx_data"}, 32'(rx_data), 32'(m_data));
      chk({tag, ".ready"},   32'(data_ready), 32'(m_rdy));
      chk({tag, ".fe"},      32'(framing_error), 32'(m_fe));
      chk({tag, ".ovr"},     32'(overrun_error), 32'(m_ovr));
      chk({tag, ".pe"},      32'(parity_error), 32'(m_pe));
      chk({tag, ".busy"},    32'(rx_busy), 32'd0);
   endtask

   // cycle (relative to the start pulse) after which data_ready is seen:
   // centre of the stop bit plus one load cycle
   function automatic int exp_rise();
      return HALF + (NB - 1) * CPB + 1;
   endfunction

   task automatic build(input logic [DB-1:0] d, input logic stop, input logic par);
      for (int k = 0; k < 256; k++) wave[k] = 1'b1;
      for (int k = 0; k < NB * CPB; k++) begin
         int b;
         b = k / CPB;
         if (b == 0)           wave[k] = 1'b0;
         else if (b <= DB)     wave[k] = d[b-1];
         else if (b == NB - 1) wave[k] = stop;
         else                  wave[k] = par;
      end
   endtask

   // wave[k] is on the line for the k-th rising edge after the start pulse;
   // obs_busy[k] is what was seen just after that edge.
   task automatic run_wave(input int ncyc, input int rst_at, input int read_at);
      logic prev;
      prev = data_ready;
      rise = -1;
      for (int k = 0; k <= ncyc; k++) begin
         @(negedge clk);
         if (k > 0) begin
            obs_busy[k-1] = rx_busy;
            if (rise < 0 && !prev && data_ready) rise = k - 1;
            prev = data_ready;
         end
         n_Rst          = (k == rst_at) ? 1'b0 : 1'b1;
         serial_in      = wave[k];
         start_detected = (k == 0);
         data_read      = (k == read_at);
      end
   endtask

   task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic par,
                              input logic read_in_load);
      m_pe = (PB != 0) ? (par != ((^d) ^ ODD[0])) : 1'b0;
      m_fe = !stop;
      if (stop) begin
         m_ovr  = read_in_load ? 1'b0 : (m_ovr | m_rdy);
         m_rdy  = 1'b1;
         m_data = d;
      end
   endtask

   task automatic send(input logic [DB-1:0] d, input logic stop, input logic par, input int read_at);
      build(d, stop, par);
      run_wave(NB * CPB + 4, -1, read_at);
      model_frame(d, stop, par, read_at >= 0);
   endtask

   task automatic do_read();
      @(negedge clk); data_read = 1'b1;
      @(negedge clk); data_read = 1'b0;
      if (m_rdy) begin m_rdy = 1'b0; m_ovr = 1'b0; end
   endtask

   function automatic logic good_par(input logic [DB-1:0] d);
      return (^d) ^ ODD[0];
   endfunction

   initial begin
      n_Rst = 1'b0; start_detected = 1'b0; serial_in = 1'b1; data_read = 1'b0;
      m_data = '0; m_rdy = 0; m_fe = 0; m_ovr = 0; m_pe = 0;
      repeat (3) @(negedge clk);
      chk_all("reset");
      n_Rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: clean frame with latency check
      send(8'hA5, 1'b1, good_par(8'hA5), -1);
      chk("t1.rise", 32'(rise), 32'(exp_rise()));
      chk("t1.busy_mid", 32'(obs_busy[1]), 32'd1);
      chk_all("t1");
      do_read();
      chk_all("t1.read");

      // 2: false start, line back high before the mid-start sample
      for (int k = 0; k < 256; k++) wave[k] = (k < 5) ? 1'b0 : 1'b1;
      run_wave(12, -1, -1);
      chk("t2.busy_pre", 32'(obs_busy[HALF-1]), 32'd1);
      chk("t2.busy_post", 32'(obs_busy[HALF]), 32'd0);
      chk_all("t2");

      // 3: framing error keeps old data
      send(8'h3C, 1'b0, good_par(8'h3C), -1);
      chk_all("t3");

      // 4: overrun, then read clears both flags
      send(8'h11, 1'b1, good_par(8'h11), -1);
      chk_all("t4a");
      send(8'h22, 1'b1, good_par(8'h22), -1);
      chk_all("t4b");
      do_read();
      chk_all("t4.read");
      do_read();   // read with nothing ready
      chk_all("t4.idle_read");

      // load and read in the same cycle: load wins, no overrun
      send(8'h5A, 1'b1, good_par(8'h5A), -1);
      send(8'hC3, 1'b1, good_par(8'hC3), exp_rise());
      chk_all("ld_rd");
      do_read();

      // 5: reset mid-frame, then a clean frame
      build(8'h99, 1'b1, good_par(8'h99));
      run_wave(NB * CPB + 4, 40, -1);
      m_data = '0; m_rdy = 0; m_fe = 0; m_ovr = 0; m_pe = 0;
      chk("t5.busy_rst", 32'(obs_busy[40]), 32'd0);
      chk_all("t5.rst");
      send(8'h7E, 1'b1, good_par(8'h7E), -1);
      chk("t5.rise", 32'(rise), 32'(exp_rise()));
      chk_all("t5");
      do_read();

`ifdef UART_RX_PARITY_EN
      // 6: bad parity still loads the frame
      send(8'h07, 1'b1, 1'b0, -1);
      chk("t6.rise", 32'(rise), 32'(exp_rise()));
      chk_all("t6");
      do_read();
`endif

      // randomized frames against the model
      for (int i = 0; i < 20; i++) begin
         logic [DB-1:0] d;
         logic stop, par;
         d    = DB'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         par  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) do_read();
         send(d, stop, par, -1);
         chk_all("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
